// File: rtl/mp64_trng_if.sv
// MP64 peripheral bus bundle for the TRNG: single-cycle request, registered response.
interface mp64_trng_if;
  logic        req;
  logic [4:0]  addr;
  logic [63:0] wdata;
  logic        wen;
  logic [63:0] rdata;
  logic        ack;

  modport master (output req, addr, wdata, wen, input rdata, ack);
  modport slave  (input req, addr, wdata, wen, output rdata, ack);
endinterface

// File: rtl/mp64_trng.sv
// MP64 true-random-number generator: two-LFSR raw bit stream folded into a
// four-word pool, read out through a nonlinear mix with backtracking feedback.
module mp64_trng #(
    parameter logic [30:0] LFSR_A_INIT = 31'h5A5A1234,
    parameter logic [28:0] LFSR_B_INIT = 29'h0C0FFEE1,
    parameter int          RCT_LIMIT   = 48
) (
    input  logic        clk,
    input  logic        rst_n,
    mp64_trng_if.slave  bus
);
    // Handshake: every cycle req is high at a rising edge is one transaction;
    // ack and rdata are registered at that same edge, there is no backpressure.
    localparam logic [4:0]  ADDR_RAND8  = 5'h00;
    localparam logic [4:0]  ADDR_RAND64 = 5'h08;
    localparam logic [4:0]  ADDR_STATUS = 5'h10;
    localparam logic [4:0]  ADDR_SEED   = 5'h18;
    localparam logic [63:0] GOLDEN      = 64'h9E3779B97F4A7C15;
    localparam logic [63:0] ZERO_SUB    = 64'hA5A5A5A5A5A5A5A5;
    localparam logic [30:0] MASK_A      = 31'h48000000;
    localparam logic [28:0] MASK_B      = 29'h14000000;
    localparam logic [7:0]  RCT         = 8'(RCT_LIMIT);

    logic [30:0] lfsr_a;
    logic [28:0] lfsr_b;
    logic [63:0] raw;
    logic [5:0]  raw_count;
    logic [1:0]  pool_idx;
    logic        pool_ready;
    logic        health_fail;
    logic [7:0]  run_len;
    logic [63:0] out_ctr;
    logic [63:0] pool     [4];
    logic [63:0] pool_nxt [4];

    logic        raw_bit;
    logic        raw_valid;
    logic [63:0] raw_nxt;
    logic        rd_fire;
    logic        seed_fire;
    logic [63:0] mix_pre;
    logic [63:0] mix_s1;
    logic [63:0] mix_s2;
    logic [63:0] mix;
    logic [63:0] mix_fb;

    assign raw_bit   = lfsr_a[0] ^ lfsr_b[0] ^ lfsr_a[17] ^ lfsr_b[11];
    assign raw_nxt   = {raw[62:0], raw_bit};
    assign raw_valid = (raw_count == 6'd63);

    assign rd_fire   = bus.req & ~bus.wen & ((bus.addr == ADDR_RAND8) | (bus.addr == ADDR_RAND64));
    assign seed_fire = bus.req & bus.wen & (bus.addr == ADDR_SEED);

    always_comb begin
        mix_pre = pool[0]
                ^ {pool[1][50:0], pool[1][63:51]}
                ^ {pool[2][34:0], pool[2][63:35]}
                ^ {pool[3][22:0], pool[3][63:23]}
                ^ (out_ctr * GOLDEN);
        mix_s1  = mix_pre ^ (mix_pre >> 33);
        mix_s2  = mix_s1 ^ (mix_s1 << 21);
        mix     = (mix_s2 == 64'd0) ? ZERO_SUB : mix_s2;
        mix_fb  = {mix[56:0], mix[63:57]};
    end

    // Raw fold, read feedback and seed may hit the same word; XORs simply stack.
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            pool_nxt[i] = pool[i];
            if (raw_valid && pool_idx == 2'(i))
                pool_nxt[i] = pool_nxt[i] ^ raw_nxt;
            if (rd_fire && out_ctr[1:0] == 2'(i))
                pool_nxt[i] = pool_nxt[i] ^ mix_fb;
            if (seed_fire && pool_idx == 2'(i))
                pool_nxt[i] = pool_nxt[i] ^ bus.wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr_a      <= LFSR_A_INIT;
            lfsr_b      <= LFSR_B_INIT;
            raw         <= '0;
            raw_count   <= '0;
            pool_idx    <= '0;
            pool_ready  <= 1'b0;
            health_fail <= 1'b0;
            run_len     <= '0;
            out_ctr     <= '0;
            for (int i = 0; i < 4; i++) pool[i] <= '0;
        end else begin
            lfsr_a    <= (lfsr_a >> 1) ^ (lfsr_a[0] ? MASK_A : 31'd0);
            lfsr_b    <= (lfsr_b >> 1) ^ (lfsr_b[0] ? MASK_B : 29'd0);
            raw       <= raw_nxt;
            raw_count <= raw_count + 6'd1;
            for (int i = 0; i < 4; i++) pool[i] <= pool_nxt[i];
            if (raw_valid) begin
                pool_idx <= pool_idx + 2'd1;
                if (pool_idx == 2'd3) pool_ready <= 1'b1;
            end
            // run_len counts the bits of the current run already in raw[0].
            if (raw_bit == raw[0]) begin
                if (run_len != 8'hFF) run_len <= run_len + 8'd1;
                if (run_len + 8'd1 >= RCT) health_fail <= 1'b1;
            end else begin
                run_len <= 8'd1;
            end
            if (rd_fire || seed_fire) out_ctr <= out_ctr + 64'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.ack   <= 1'b0;
            bus.rdata <= '0;
        end else begin
            bus.ack <= bus.req;
            if (bus.req && !bus.wen) begin
                case (bus.addr)
                    ADDR_RAND8:  bus.rdata <= {56'd0, mix[7:0]};
                    ADDR_RAND64: bus.rdata <= mix;
                    ADDR_STATUS: bus.rdata <= {62'd0, health_fail, pool_ready & ~health_fail};
                    default:     bus.rdata <= '0;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_mp64_trng.sv
// Directed bench for mp64_trng: driver pushes expectations, a monitor pops on ack.
module tb_mp64_trng;
  localparam int K_EXACT   = 0;
  localparam int K_NONZERO = 1;
  localparam int K_DIFF    = 2;
  localparam int K_HOLD    = 3;
  localparam int K_BYTE    = 4;
  localparam logic [63:0] ALL  = 64'hFFFF_FFFF_FFFF_FFFF;
  localparam logic [63:0] HIGH = 64'hFFFF_FFFF_FFFF_FF00;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mp64_trng_if bus ();
  mp64_trng dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  logic [63:0] exp_q[$];
  logic [63:0] mask_q[$];
  int          kind_q[$];
  string       name_q[$];
  logic [7:0]  bytes_q[$];
  logic [63:0] last_rdata;
  int          checks = 0;
  int          passes = 0;

  task automatic check(input string name, input logic ok,
                       input logic [63:0] act, input logic [63:0] req_v);
    checks++;
    if (ok) passes++;
    else $display("FAIL %s: got %h required %h", name, act, req_v);
  endtask

  // Monitor: pops one expectation per ack and classifies the response.
  initial begin
    logic [63:0] r, e, m;
    int k;
    string n;
    last_rdata = 64'd0;
    forever begin
      @(posedge clk);
      #1;
      if (rst_n && bus.ack) begin
        r = bus.rdata;
        if (exp_q.size() == 0) begin
          check("unexpected_ack", 1'b0, r, 64'd0);
        end else begin
          e = exp_q.pop_front();
          m = mask_q.pop_front();
          k = kind_q.pop_front();
          n = name_q.pop_front();
          case (k)
            K_EXACT:   check(n, (r & m) == e, r & m, e);
            K_NONZERO: check(n, r != 64'd0, r, 64'd1);
            K_DIFF:    check(n, r != last_rdata, r, ~last_rdata);
            K_HOLD:    check(n, r == last_rdata, r, last_rdata);
            default: begin
              check(n, (r & m) == e, r & m, e);
              bytes_q.push_back(r[7:0]);
            end
          endcase
        end
        last_rdata = r;
      end
    end
  end

  task automatic bus_op(input logic w, input logic [4:0] a, input logic [63:0] d,
                        input int k, input logic [63:0] e, input logic [63:0] m,
                        input string n);
    @(negedge clk);
    bus.req   = 1'b1;
    bus.wen   = w;
    bus.addr  = a;
    bus.wdata = d;
    exp_q.push_back(e);
    mask_q.push_back(m);
    kind_q.push_back(k);
    name_q.push_back(n);
  endtask

  task automatic idle(input int n);
    @(negedge clk);
    bus.req = 1'b0;
    bus.wen = 1'b0;
    repeat (n) @(posedge clk);
  endtask

  task automatic drain(input string n);
    for (int i = 0; i < 50 && exp_q.size() != 0; i++) @(posedge clk);
    #2;
    check(n, exp_q.size() == 0, 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    int distinct;
    bus.req = 1'b0; bus.wen = 1'b0; bus.addr = '0; bus.wdata = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_rdata", bus.rdata == 64'd0, bus.rdata, 64'd0);
    check("reset_ack", {63'd0, bus.ack} == 64'd0, {63'd0, bus.ack}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);

    bus_op(1'b0, 5'h10, '0, K_EXACT, 64'd0, ALL, "status_not_ready");
    idle(300);
    bus_op(1'b0, 5'h10, '0, K_EXACT, 64'd1, ALL, "status_ready");
    bus_op(1'b0, 5'h00, '0, K_EXACT, 64'd0, HIGH, "rand8_upper_zero");
    bus_op(1'b0, 5'h08, '0, K_NONZERO, '0, ALL, "rand64_nonzero");
    bus_op(1'b0, 5'h08, '0, K_DIFF, '0, ALL, "rand64_b2b_differ");
    idle(2);
    drain("drain_basic");

    bus_op(1'b1, 5'h18, 64'hDEADBEEFCAFEBABE, K_HOLD, '0, ALL, "seed1_rdata_hold");
    idle(1);
    bus_op(1'b0, 5'h00, '0, K_EXACT, 64'd0, HIGH, "rand8_before_seed");
    bus_op(1'b1, 5'h18, 64'h1234567890ABCDEF, K_HOLD, '0, ALL, "seed2_rdata_hold");
    bus_op(1'b0, 5'h00, '0, K_DIFF, '0, ALL, "rand8_after_seed_differs");
    idle(2);
    drain("drain_seed");
    #1;
    check("ack_idle_low", {63'd0, bus.ack} == 64'd0, {63'd0, bus.ack}, 64'd0);

    bytes_q.delete();
    for (int i = 0; i < 8; i++) bus_op(1'b0, 5'h00, '0, K_BYTE, 64'd0, HIGH, "rand8_burst_upper");
    idle(2);
    drain("drain_burst");
    distinct = 0;
    for (int i = 0; i < bytes_q.size(); i++) begin
      bit seen = 1'b0;
      for (int j = 0; j < i; j++) if (bytes_q[j] == bytes_q[i]) seen = 1'b1;
      if (!seen) distinct++;
    end
    check("rand8_distinct", distinct >= 2, 64'(distinct), 64'd2);

    for (int i = 0; i < 100; i++) bus_op(1'b0, 5'h08, '0, K_NONZERO, '0, ALL, "rand64_run_nonzero");
    bus_op(1'b0, 5'h10, '0, K_EXACT, 64'd1, ALL, "status_healthy");
    bus_op(1'b0, 5'h18, '0, K_EXACT, 64'd0, ALL, "seed_reads_zero");
    bus_op(1'b0, 5'h04, '0, K_EXACT, 64'd0, ALL, "unmapped_reads_zero");
    idle(2);
    drain("drain_final");

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule

// File: doc/mp64_trng.md
Name: mp64_trng

Overview:
- Memory-mapped true-random-number generator peripheral on the MP64 peripheral bus.
- Entropy comes from a free-running digital entropy model: two LFSRs sampled as a 1-bit raw stream. It is collected into 64-bit raw words and folded into a 4-word entropy pool.
- Output is a nonlinear mix of the pool with a per-read counter.
- Exposes RAND8, RAND64, STATUS and SEED registers through a single-cycle request / registered-response bus.

Parameters:
- LFSR_A_INIT, 31'h5A5A1234, reset value of 31-bit entropy LFSR A (must be nonzero).
- LFSR_B_INIT, 29'h0C0FFEE1, reset value of 29-bit entropy LFSR B (must be nonzero).
- RCT_LIMIT, 48, repetition-count health limit: this many consecutive identical raw bits latches a health failure.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset; one clock; reset is asynchronous and active-low.
- req  in  1  bus request, sampled on rising clk; each cycle high is one transaction.
- addr  in  5  register byte offset.
- wdata  in  64  write data.
- wen  in  1  1 = write, 0 = read; qualified by req.
- rdata  out  64  registered read data.
- ack  out  1  one-cycle transaction acknowledge.

Behaviour:
- Register map:
  - 0x00 RAND8 (R): {56'b0, mix[7:0]}.
  - 0x08 RAND64 (R): mix[63:0].
  - 0x10 STATUS (R): bit0 = pool_ready & ~health_fail; bit1 = health_fail; bits 63:2 = 0.
  - 0x18 SEED (W): reads as 0.
  - Other offsets: read 0, writes ignored. Writes to read-only registers are ignored.
- Bus timing:
  - req sampled at edge N; ack=1 and rdata updated at edge N (visible during cycle N+1). ack returns to 0 next edge unless req is still high.
  - rdata holds its value until the next read.
  - Writes also ack; writes leave rdata unchanged.
- Reset: rdata=0, ack=0, pool words=0, pool_idx=0, raw_count=0, raw shift reg=0, pool_ready=0, health_fail=0, out_ctr=0, LFSRs to INIT parameters.
- Entropy source:
  - Both LFSRs step every clk, maximal-length Galois form.
  - raw_bit = A[0] ^ B[0] ^ A[17] ^ B[11].
- Collection:
  - raw_bit shifts into a 64-bit raw register every clk.
  - raw_count is 6 bits and increments every clk.
  - When raw_count wraps 63→0, raw_valid pulses for one cycle: pool[pool_idx] ^= raw; pool_idx increments (2 bits, wraps 3→0).
  - When pool_idx wraps 3→0, pool_ready sets and stays set until reset. This is the 4th raw_valid, about 256 clocks after reset.
- Mix (combinational):
  - mix = pool0 ^ rotl(pool1,13) ^ rotl(pool2,29) ^ rotl(pool3,41) ^ (out_ctr * 64'h9E3779B97F4A7C15), then one xorshift round (x^=x>>33; x^=x<<21).
  - If the result is 0, substitute 64'hA5A5A5A5A5A5A5A5, so RAND64 is never 0.
- Read side effects (RAND8 or RAND64):
  - out_ctr increments.
  - pool[out_ctr[1:0]] ^= rotl(mix,7), giving backtracking resistance.
  - Consecutive reads therefore never return the same state.
- SEED write: pool[pool_idx] ^= wdata, and out_ctr increments.
- Simultaneous events: if raw_valid, a read feedback or a SEED XOR target the same pool word in one cycle, apply all XORs together (XOR is commutative).
- Reads before pool_ready are allowed and return mixed (weak) data. Software must poll STATUS.
- Health monitor:
  - Tracks the run length of identical consecutive raw bits.
  - A run ≥ RCT_LIMIT sets health_fail. The flag is sticky and cleared only by reset.
- Reset mid-transaction: the async reset immediately clears ack and rdata; the transaction is lost.

Test Plan:
- Reset, wait 2 clocks, read 0x10 -> rdata = 0.
- Idle 300 clocks, read 0x10 -> rdata = 64'h1.
- Read 0x00 -> rdata[63:8] = 0. Read 0x08 -> nonzero. Two back-to-back 0x08 reads -> values differ.
- Write 0x18 = 64'hDEADBEEFCAFEBABE -> ack pulses, no hang. Read 0x00, write 0x18 = 64'h1234567890ABCDEF, read 0x00 -> the two RAND8 values differ.
- Eight consecutive 0x00 reads -> at least 2 distinct bytes.
- 100 consecutive 0x08 reads, then read 0x10 -> still 64'h1 (no health alarm). Read 0x18 -> 0; read unmapped 0x04 -> 0.
